commit_serial_ctrl: RTL and testbench
=====================================

Name: commit_serial_ctrl

Overview:
- Sequences "single-commit" special instructions at the ROB head: uncached load/store, cache maintenance (cacop), TLB maintenance, dbar, ibar and CSR write.
- Sits beside the commit stage. It stalls dual commit while active, drains the store buffer, and drives the shared uncached/cacop memory port and the TLB maintenance port.
- It then issues a one-cycle retire pulse and, where required, a pipeline flush with refetch PC.

Parameters:
- ADDR_W, 32, address/PC width
- DATA_W, 32, data width
- OP_W, 5, cacop/TLB sub-opcode width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- head_valid_i  in  1  ROB head entry valid and ready to commit
- head_kind_i  in  3  0 normal, 1 uc_load, 2 uc_store, 3 cacop, 4 tlb, 5 dbar, 6 ibar, 7 csr
- head_pc_i  in  ADDR_W  PC of head
- head_addr_i  in  ADDR_W  memory/cacop address
- head_wdata_i  in  DATA_W  store data
- head_op_i  in  OP_W  cacop/TLB sub-op
- flush_i  in  1  external flush (exception/mispredict) from commit
- sb_empty_i  in  1  committed store buffer empty
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  1 = uncached store
- mem_cacop_o  out  1  1 = cacop request
- mem_addr_o  out  ADDR_W  request address
- mem_wdata_o  out  DATA_W  request store data
- mem_op_o  out  OP_W  cacop sub-op
- mem_ready_i  in  1  request accepted
- mem_resp_i  in  1  response/ack valid
- mem_rdata_i  in  DATA_W  load data
- tlb_req_o  out  1  TLB op valid
- tlb_op_o  out  OP_W  TLB sub-op
- tlb_done_i  in  1  TLB op complete (pulse)
- stall_o  out  1  block commit of head and slot 1
- retire_o  out  1  one-cycle retire pulse for head
- retire_rdata_o  out  DATA_W  uc_load result, valid with retire_o
- flush_o  out  1  one-cycle pipeline flush
- flush_pc_o  out  ADDR_W  refetch PC = latched pc + 4

Behaviour:
- Reset: state IDLE, all outputs 0, latched fields 0.
- stall_o = (state != IDLE) | (head_valid_i & head_kind_i != 0 & !flush_i). Combinational. Kind 0 never leaves IDLE.
- States: IDLE, DRAIN, ISSUE, WAIT, RETIRE, ABORT.
- IDLE -> DRAIN on head_valid_i & kind != 0 & !flush_i. Latch kind, pc, addr, wdata, op in the same edge.
- DRAIN: hold until sb_empty_i.
  - dbar, ibar, csr -> RETIRE.
  - uc_load, uc_store, cacop, tlb -> ISSUE.
  - Zero extra cycles if sb_empty_i is already 1 on entry.
- ISSUE:
  - memory kinds: mem_req_o = 1 with stable addr/wdata/we/cacop/op until mem_ready_i. Handshake on req & ready, then -> WAIT.
  - tlb: tlb_req_o = 1 for exactly one cycle, then -> WAIT.
- WAIT: memory kinds wait for mem_resp_i (capture mem_rdata_i); tlb waits for tlb_done_i. Then -> RETIRE. A response in the same cycle as the handshake is not legal and is not required to be handled.
- RETIRE: one cycle. retire_o = 1 and retire_rdata_o = captured data (0 for non-loads). Then -> IDLE.
  - flush_o = 1 with flush_pc_o = pc + 4 (wraps modulo 2^ADDR_W) for cacop, tlb, ibar, csr.
  - No flush for uc_load, uc_store, dbar.
- The IDLE cycle after RETIRE samples the new (advanced) head normally. Back-to-back special ops are allowed.
- flush_i handling:
  - In DRAIN, or in ISSUE before handshake (memory) or before tlb_req_o has been sent: -> IDLE, no retire, no request outstanding.
  - In WAIT: -> ABORT. ABORT swallows the pending mem_resp_i/tlb_done_i, then -> IDLE with no retire and no flush. stall_o stays 1 throughout ABORT.
  - flush_i in RETIRE is ignored; the retire completes.
- mem_req_o and tlb_req_o are never asserted together. At most one outstanding operation at any time.
- Asynchronous reset mid-operation returns to IDLE immediately. The outstanding response is the memory/TLB side's responsibility (reset together).

Test Plan:
- kind=0 head valid -> stall_o=0, no requests, state stays IDLE.
- dbar with sb_empty_i=0 for 5 cycles -> stall_o=1 for 5 DRAIN cycles, then retire_o pulse, flush_o=0.
- uc_load addr=0x1C00_0040, mem_ready_i delayed 3 cycles, resp rdata=0xDEAD_BEEF -> mem_req_o held stable 4 cycles, retire_o with retire_rdata_o=0xDEAD_BEEF, no flush.
- cacop pc=0x1C00_0100 -> after ack, retire_o and flush_o together, flush_pc_o=0x1C00_0104.
- tlb op with flush_i asserted while in WAIT -> ABORT until tlb_done_i, no retire_o/flush_o, back to IDLE.
- csr at pc=0xFFFF_FFFC -> retire_o and flush_o, flush_pc_o=0x0000_0000. Then uc_store immediately at the next head -> second sequence starts in the IDLE cycle after RETIRE.

Source files
------------

// File: rtl/commit_serial_ctrl.sv
// Serialises single-commit special instructions at the ROB head: drains the store
// buffer, issues one uncached/cacop or TLB operation, then retires (and flushes if needed).
module commit_serial_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              head_valid_i,
    input  logic [2:0]        head_kind_i,
    input  logic [ADDR_W-1:0] head_pc_i,
    input  logic [ADDR_W-1:0] head_addr_i,
    input  logic [DATA_W-1:0] head_wdata_i,
    input  logic [OP_W-1:0]   head_op_i,
    input  logic              flush_i,
    input  logic              sb_empty_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              mem_cacop_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [OP_W-1:0]   mem_op_o,
    input  logic              mem_ready_i,
    input  logic              mem_resp_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              tlb_req_o,
    output logic [OP_W-1:0]   tlb_op_o,
    input  logic              tlb_done_i,
    output logic              stall_o,
    output logic              retire_o,
    output logic [DATA_W-1:0] retire_rdata_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] flush_pc_o
);

    typedef enum logic [2:0] {
        K_NORMAL   = 3'd0,
        K_UC_LOAD  = 3'd1,
        K_UC_STORE = 3'd2,
        K_CACOP    = 3'd3,
        K_TLB      = 3'd4,
        K_DBAR     = 3'd5,
        K_IBAR     = 3'd6,
        K_CSR      = 3'd7
    } kind_e;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_ISSUE, S_WAIT, S_RETIRE, S_ABORT
    } state_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic is_mem_kind, is_tlb_kind, needs_flush, op_done, start;

    always_comb begin
        is_mem_kind = (kind_q == K_UC_LOAD) || (kind_q == K_UC_STORE) || (kind_q == K_CACOP);
        is_tlb_kind = (kind_q == K_TLB);
        needs_flush = (kind_q == K_CACOP) || (kind_q == K_TLB) ||
                      (kind_q == K_IBAR)  || (kind_q == K_CSR);
        op_done     = is_tlb_kind ? tlb_done_i : mem_resp_i;
        start       = head_valid_i && (head_kind_i != K_NORMAL) && !flush_i;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        pc_d           = pc_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        op_d           = op_q;
        rdata_d        = rdata_q;
        mem_req_o      = 1'b0;
        tlb_req_o      = 1'b0;
        retire_o       = 1'b0;
        flush_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRAIN;
                    kind_d  = kind_e'(head_kind_i);
                    pc_d    = head_pc_i;
                    addr_d  = head_addr_i;
                    wdata_d = head_wdata_i;
                    op_d    = head_op_i;
                    rdata_d = '0;
                end
            end
            S_DRAIN: begin
                if (flush_i)
                    state_d = S_IDLE;
                else if (sb_empty_i)
                    state_d = (is_mem_kind || is_tlb_kind) ? S_ISSUE : S_RETIRE;
            end
            S_ISSUE: begin
                // A request that goes out in the flush cycle is still outstanding,
                // so its completion must be swallowed in ABORT.
                if (is_tlb_kind) begin
                    tlb_req_o = 1'b1;
                    state_d   = flush_i ? S_ABORT : S_WAIT;
                end else begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i)
                        state_d = flush_i ? S_ABORT : S_WAIT;
                    else if (flush_i)
                        state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (op_done && kind_q == K_UC_LOAD && !flush_i)
                    rdata_d = mem_rdata_i;
                if (flush_i)
                    state_d = op_done ? S_IDLE : S_ABORT;
                else if (op_done)
                    state_d = S_RETIRE;
            end
            S_RETIRE: begin
                retire_o = 1'b1;
                flush_o  = needs_flush;
                state_d  = S_IDLE;
            end
            S_ABORT: begin
                if (op_done)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Payload outputs are gated so they read 0 whenever their qualifier is low.
    always_comb begin
        stall_o        = (state_q != S_IDLE) || start;
        mem_we_o       = mem_req_o && (kind_q == K_UC_STORE);
        mem_cacop_o    = mem_req_o && (kind_q == K_CACOP);
        mem_addr_o     = mem_req_o ? addr_q  : '0;
        mem_wdata_o    = mem_req_o ? wdata_q : '0;
        mem_op_o       = mem_cacop_o ? op_q  : '0;
        tlb_op_o       = tlb_req_o ? op_q    : '0;
        retire_rdata_o = retire_o ? rdata_q  : '0;
        flush_pc_o     = flush_o ? (pc_q + ADDR_W'(4)) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_NORMAL;
            pc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_commit_serial_ctrl.sv
// Directed self-checking bench for commit_serial_ctrl; inputs change and outputs are
// sampled 2ns after each rising edge.
module tb_commit_serial_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              head_valid_i;
    logic [2:0]        head_kind_i;
    logic [ADDR_W-1:0] head_pc_i;
    logic [ADDR_W-1:0] head_addr_i;
    logic [DATA_W-1:0] head_wdata_i;
    logic [OP_W-1:0]   head_op_i;
    logic              flush_i;
    logic              sb_empty_i;
    logic              mem_req_o;
    logic              mem_we_o;
    logic              mem_cacop_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [OP_W-1:0]   mem_op_o;
    logic              mem_ready_i;
    logic              mem_resp_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              tlb_req_o;
    logic [OP_W-1:0]   tlb_op_o;
    logic              tlb_done_i;
    logic              stall_o;
    logic              retire_o;
    logic [DATA_W-1:0] retire_rdata_o;
    logic              flush_o;
    logic [ADDR_W-1:0] flush_pc_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    commit_serial_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .head_valid_i   (head_valid_i),
        .head_kind_i    (head_kind_i),
        .head_pc_i      (head_pc_i),
        .head_addr_i    (head_addr_i),
        .head_wdata_i   (head_wdata_i),
        .head_op_i      (head_op_i),
        .flush_i        (flush_i),
        .sb_empty_i     (sb_empty_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_cacop_o    (mem_cacop_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_op_o       (mem_op_o),
        .mem_ready_i    (mem_ready_i),
        .mem_resp_i     (mem_resp_i),
        .mem_rdata_i    (mem_rdata_i),
        .tlb_req_o      (tlb_req_o),
        .tlb_op_o       (tlb_op_o),
        .tlb_done_i     (tlb_done_i),
        .stall_o        (stall_o),
        .retire_o       (retire_o),
        .retire_rdata_o (retire_rdata_o),
        .flush_o        (flush_o),
        .flush_pc_o     (flush_pc_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_head(input logic [2:0] kind, input logic [31:0] pc,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] op);
        head_valid_i = 1'b1;
        head_kind_i  = kind;
        head_pc_i    = pc;
        head_addr_i  = addr;
        head_wdata_i = wdata;
        head_op_i    = op;
    endtask

    initial begin
        rst_n = 1'b0;
        head_valid_i = 1'b0; head_kind_i = '0; head_pc_i = '0; head_addr_i = '0;
        head_wdata_i = '0; head_op_i = '0; flush_i = 1'b0; sb_empty_i = 1'b1;
        mem_ready_i = 1'b0; mem_resp_i = 1'b0; mem_rdata_i = '0; tlb_done_i = 1'b0;

        // Reset state
        #12;
        check("rst_stall",   stall_o, 0);
        check("rst_memreq",  mem_req_o, 0);
        check("rst_tlbreq",  tlb_req_o, 0);
        check("rst_retire",  retire_o, 0);
        check("rst_flush",   flush_o, 0);
        check("rst_flushpc", flush_pc_o, 0);
        check("rst_rdata",   retire_rdata_o, 0);
        rst_n = 1'b1;
        step();

        // Normal instruction never engages the controller
        set_head(3'd0, 32'h1C00_0000, 32'h0, 32'h0, 5'h0);
        #1 check("k0_stall_comb", stall_o, 0);
        step();
        check("k0_stall", stall_o, 0);
        check("k0_memreq", mem_req_o, 0);
        check("k0_tlbreq", tlb_req_o, 0);
        head_valid_i = 1'b0;
        step();

        // dbar with store buffer busy for 5 DRAIN cycles
        sb_empty_i = 1'b0;
        set_head(3'd5, 32'h1C00_0010, 32'h0, 32'h0, 5'h0);
        #1 check("dbar_stall_comb", stall_o, 1);
        step();
        head_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("dbar_drain_stall%0d", i), stall_o, 1);
            check($sformatf("dbar_drain_retire%0d", i), retire_o, 0);
            if (i == 4) sb_empty_i = 1'b1;
            step();
        end
        check("dbar_retire", retire_o, 1);
        check("dbar_noflush", flush_o, 0);
        check("dbar_rdata", retire_rdata_o, 0);
        step();
        check("dbar_idle_retire", retire_o, 0);
        check("dbar_idle_stall", stall_o, 0);

        // uc_load with mem_ready_i delayed 3 cycles
        set_head(3'd1, 32'h1C00_0080, 32'h1C00_0040, 32'h0, 5'h0);
        step();
        head_valid_i = 1'b0;
        check("ld_drain_noreq", mem_req_o, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ld_req%0d", i), mem_req_o, 1);
            check($sformatf("ld_addr%0d", i), mem_addr_o, 32'h1C00_0040);
            check($sformatf("ld_we%0d", i), mem_we_o, 0);
            check($sformatf("ld_cacop%0d", i), mem_cacop_o, 0);
            if (i == 3) mem_ready_i = 1'b1;
            step();
        end
        mem_ready_i = 1'b0;
        check("ld_wait_noreq", mem_req_o, 0);
        check("ld_wait_noretire", retire_o, 0);
        mem_resp_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        step();
        mem_resp_i = 1'b0; mem_rdata_i = '0;
        check("ld_retire", retire_o, 1);
        check("ld_rdata", retire_rdata_o, 32'hDEAD_BEEF);
        check("ld_noflush", flush_o, 0);
        step();
        check("ld_idle_retire", retire_o, 0);

        // cacop: retire with flush to pc + 4
        set_head(3'd3, 32'h1C00_0100, 32'h1C00_2000, 32'h0, 5'h09);
        step();
        head_valid_i = 1'b0;
        step();
        check("cacop_req", mem_req_o, 1);
        check("cacop_flag", mem_cacop_o, 1);
        check("cacop_op", mem_op_o, 5'h09);
        check("cacop_addr", mem_addr_o, 32'h1C00_2000);
        check("cacop_we", mem_we_o, 0);
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        mem_resp_i = 1'b1;
        step();
        mem_resp_i = 1'b0;
        check("cacop_retire", retire_o, 1);
        check("cacop_flush", flush_o, 1);
        check("cacop_flushpc", flush_pc_o, 32'h1C00_0104);
        check("cacop_rdata", retire_rdata_o, 0);
        step();
        check("cacop_idle_flush", flush_o, 0);

        // tlb op flushed while in WAIT -> ABORT until tlb_done_i
        set_head(3'd4, 32'h1C00_0200, 32'h0, 32'h0, 5'h03);
        step();
        head_valid_i = 1'b0;
        step();
        check("tlb_req", tlb_req_o, 1);
        check("tlb_op", tlb_op_o, 5'h03);
        check("tlb_nomem", mem_req_o, 0);
        step();
        check("tlb_req_once", tlb_req_o, 0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_stall%0d", i), stall_o, 1);
            check($sformatf("abort_retire%0d", i), retire_o, 0);
            check($sformatf("abort_flush%0d", i), flush_o, 0);
            step();
        end
        tlb_done_i = 1'b1;
        #1 check("abort_done_retire", retire_o, 0);
        step();
        tlb_done_i = 1'b0;
        check("abort_idle_stall", stall_o, 0);
        check("abort_idle_retire", retire_o, 0);
        check("abort_idle_flush", flush_o, 0);
        step();
        check("abort_after_retire", retire_o, 0);

        // flush in DRAIN abandons the op with nothing outstanding
        sb_empty_i = 1'b0;
        set_head(3'd1, 32'h1C00_0280, 32'h1C00_3000, 32'h0, 5'h0);
        step();
        head_valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        sb_empty_i = 1'b1;
        check("drflush_stall", stall_o, 0);
        step();
        check("drflush_noreq", mem_req_o, 0);
        check("drflush_noretire", retire_o, 0);

        // csr at top of address space wraps, then uc_store back-to-back
        set_head(3'd7, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'h0);
        step();
        step();
        check("csr_retire", retire_o, 1);
        check("csr_flush", flush_o, 1);
        check("csr_flushpc_wrap", flush_pc_o, 32'h0000_0000);
        set_head(3'd2, 32'h1C00_0300, 32'h1C00_4000, 32'h1234_5678, 5'h0);
        step();
        check("st_idle_stall", stall_o, 1);
        check("st_idle_retire", retire_o, 0);
        step();
        head_valid_i = 1'b0;
        check("st_drain_noreq", mem_req_o, 0);
        step();
        check("st_req", mem_req_o, 1);
        check("st_we", mem_we_o, 1);
        check("st_addr", mem_addr_o, 32'h1C00_4000);
        check("st_wdata", mem_wdata_o, 32'h1234_5678);
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        mem_resp_i = 1'b1;
        step();
        mem_resp_i = 1'b0;
        check("st_retire", retire_o, 1);
        check("st_noflush", flush_o, 0);
        check("st_rdata", retire_rdata_o, 0);
        step();
        check("st_idle_stall_end", stall_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
